// File: rtl/jtgng_objdraw_gen.sv
// Sprite line drawer: takes one descriptor, checks it against the line, fetches ROM rows, writes opaque pixels.
// Latency 2 cen cycles when the sprite misses the line, else 2 + (SPRW/8)*9 plus ROM waits; obj_ready is low while busy.
// Backpressure: rom_cs is held with a stable rom_addr until rom_ok is seen on a cen cycle; start aborts at once.
module jtgng_objdraw_gen #(
    parameter int PW   = 4,
    parameter int PALW = 4,
    parameter int CW   = 8,
    parameter int HW   = 9,
    parameter int VW   = 8,
    parameter int SPRW = 16,
    parameter logic [PW-1:0] TRANSP = {PW{1'b1}},
    localparam int FW  = $clog2(SPRW/8),
    localparam int AW  = CW + 4 + FW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cen,
    input  logic            flip,
    input  logic [VW-1:0]   V,
    input  logic            start,
    input  logic            obj_valid,
    output logic            obj_ready,
    input  logic [CW-1:0]   obj_code,
    input  logic [PALW-1:0] obj_pal,
    input  logic [HW-1:0]   obj_x,
    input  logic [VW-1:0]   obj_y,
    input  logic [1:0]      obj_vlen,
    input  logic            obj_hflip,
    output logic [AW-1:0]   rom_addr,
    output logic            rom_cs,
    input  logic            rom_ok,
    input  logic [8*PW-1:0] rom_data,
    output logic            buf_we,
    output logic [HW-1:0]   buf_addr,
    output logic [PALW+PW-1:0] buf_data,
    output logic            idle
);

    localparam int NF  = SPRW / 8;
    localparam int FCW = (FW > 0) ? FW : 1;

    typedef enum logic [1:0] {IDLE, CHECK, FETCH, DRAW} state_t;

    typedef struct packed {
        logic [CW-1:0]   code;
        logic [PALW-1:0] pal;
        logic [HW-1:0]   x;
        logic [VW-1:0]   y;
        logic [1:0]      vlen;
        logic            hflip;
    } desc_t;

    state_t               state, state_nxt;
    desc_t                desc;
    logic [CW-1:0]        code_eff_r;
    logic [3:0]           row_r;
    logic                 eh_r;
    logic [FCW-1:0]       f_r;
    logic [2:0]           pix_r;
    logic [PW-1:0][7:0]   sh_r;

    logic [VW-1:0]        vf, dy;
    logic [VW:0]          lim;
    logic                 in_zone;
    logic [CW-1:0]        code_eff;
    logic                 eh_c;
    logic [FCW-1:0]       fidx0, f_nxt, fidx_nxt;
    logic [AW-1:0]        addr_chk, addr_nxt;
    logic [PW-1:0]        pix;
    logic                 last_f;

    always_comb begin
        vf       = flip ? ~V : V;
        dy       = vf - desc.y;
        lim      = (VW+1)'(16) << desc.vlen;
        in_zone  = {1'b0, dy} < lim;
        // tall sprites stack consecutive codes: low code bits come from the row
        code_eff = desc.code;
        for (int k = 0; k < 3; k++) begin
            if (k < int'(desc.vlen)) code_eff[k] = dy[4+k];
        end
        eh_c     = desc.hflip ^ flip;
        fidx0    = eh_c ? FCW'(NF-1) : '0;
        addr_chk = (AW'({code_eff, dy[3:0]}) << FW) | AW'(fidx0);
        f_nxt    = f_r + 1'b1;
        fidx_nxt = eh_r ? FCW'(NF-1) - f_nxt : f_nxt;
        addr_nxt = (AW'({code_eff_r, row_r}) << FW) | AW'(fidx_nxt);
        last_f   = (f_r == FCW'(NF-1));
        pix      = '0;
        for (int p = 0; p < PW; p++) begin
            pix[p] = eh_r ? sh_r[p][0] : sh_r[p][7];
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (obj_valid) state_nxt = CHECK;
            CHECK: state_nxt = in_zone ? FETCH : IDLE;
            FETCH: if (rom_ok) state_nxt = DRAW;
            DRAW:  if (pix_r == 3'd7) state_nxt = last_f ? IDLE : FETCH;
            default: state_nxt = IDLE;
        endcase
        if (start) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            desc       <= '0;
            code_eff_r <= '0;
            row_r      <= '0;
            eh_r       <= 1'b0;
            f_r        <= '0;
            pix_r      <= '0;
            sh_r       <= '0;
            obj_ready  <= 1'b1;
            idle       <= 1'b1;
            rom_cs     <= 1'b0;
            rom_addr   <= '0;
            buf_we     <= 1'b0;
            buf_addr   <= '0;
            buf_data   <= '0;
        end else if (cen) begin
            state     <= state_nxt;
            obj_ready <= (state_nxt == IDLE);
            idle      <= (state_nxt == IDLE);
            buf_we    <= 1'b0;
            if (start) begin
                rom_cs <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (obj_valid) begin
                        desc <= '{code: obj_code, pal: obj_pal, x: obj_x, y: obj_y,
                                  vlen: obj_vlen, hflip: obj_hflip};
                    end
                    CHECK: begin
                        code_eff_r <= code_eff;
                        row_r      <= dy[3:0];
                        eh_r       <= eh_c;
                        f_r        <= '0;
                        if (in_zone) begin
                            rom_cs   <= 1'b1;
                            rom_addr <= addr_chk;
                        end
                    end
                    FETCH: if (rom_ok) begin
                        sh_r   <= rom_data;
                        rom_cs <= 1'b0;
                        pix_r  <= '0;
                    end
                    DRAW: begin
                        buf_we   <= (pix != TRANSP);
                        buf_addr <= desc.x + HW'({f_r, pix_r});
                        buf_data <= {desc.pal, pix};
                        for (int p = 0; p < PW; p++) begin
                            sh_r[p] <= eh_r ? {1'b0, sh_r[p][7:1]} : {sh_r[p][6:0], 1'b0};
                        end
                        pix_r <= pix_r + 3'd1;
                        if (pix_r == 3'd7 && !last_f) begin
                            f_r      <= f_nxt;
                            rom_addr <= addr_nxt;
                            rom_cs   <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_jtgng_objdraw_gen.sv
// Directed bench for jtgng_objdraw_gen with default parameters (PW=4, SPRW=16, 13-bit rom_addr).
module tb_jtgng_objdraw_gen;

    logic        clk = 1'b0;
    logic        rst_n, cen, flip, start, obj_valid, obj_ready, obj_hflip;
    logic [7:0]  V, obj_code, obj_y;
    logic [3:0]  obj_pal;
    logic [8:0]  obj_x;
    logic [1:0]  obj_vlen;
    logic [12:0] rom_addr;
    logic        rom_cs, rom_ok, buf_we, idle;
    logic [31:0] rom_data;
    logic [8:0]  buf_addr;
    logic [7:0]  buf_data;

    int n_cmp = 0;
    int n_err = 0;

    jtgng_objdraw_gen dut (
        .clk(clk), .rst_n(rst_n), .cen(cen), .flip(flip), .V(V), .start(start),
        .obj_valid(obj_valid), .obj_ready(obj_ready), .obj_code(obj_code), .obj_pal(obj_pal),
        .obj_x(obj_x), .obj_y(obj_y), .obj_vlen(obj_vlen), .obj_hflip(obj_hflip),
        .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_ok(rom_ok), .rom_data(rom_data),
        .buf_we(buf_we), .buf_addr(buf_addr), .buf_data(buf_data), .idle(idle)
    );

    always #5 clk = ~clk;

    // write recorder and ROM responder, sampled 1 time unit after each rising edge
    logic [8:0]  wa_q[$];
    logic [7:0]  wd_q[$];
    logic [12:0] ra_q[$];
    int          cs_cycles = 0, addr_jumps = 0, ok_wait = 0, wait_cnt = 0;
    logic        prev_cs = 1'b0;
    logic [12:0] prev_ra = '0;

    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            rom_ok = 1'b0; wait_cnt = 0; prev_cs = 1'b0;
        end else begin
            if (buf_we) begin wa_q.push_back(buf_addr); wd_q.push_back(buf_data); end
            if (rom_cs) begin
                cs_cycles++;
                if (!prev_cs) ra_q.push_back(rom_addr);
                else if (rom_addr !== prev_ra) addr_jumps++;
                if (wait_cnt < ok_wait) begin rom_ok = 1'b0; wait_cnt++; end
                else rom_ok = 1'b1;
            end else begin
                rom_ok = 1'b0; wait_cnt = 0;
            end
            prev_cs = rom_cs; prev_ra = rom_addr;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no end, required end");
        $fatal(1, "watchdog");
    end

    task automatic clear_log();
        wa_q.delete(); wd_q.delete(); ra_q.delete();
        cs_cycles = 0; addr_jumps = 0;
    endtask

    task automatic send(input logic [7:0] code, input logic [3:0] pal, input logic [8:0] x,
                        input logic [7:0] y, input logic [1:0] vlen, input logic hf);
        @(negedge clk);
        obj_code = code; obj_pal = pal; obj_x = x; obj_y = y; obj_vlen = vlen; obj_hflip = hf;
        obj_valid = 1'b1;
        @(negedge clk);
        obj_valid = 1'b0;
    endtask

    // counts negedges from the one after the transfer edge until idle is seen
    task automatic wait_idle(output int n);
        n = 0;
        while (!idle && n < 200) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cen = 1'b1; flip = 1'b0; start = 1'b0; obj_valid = 1'b0;
        V = '0; obj_code = '0; obj_pal = '0; obj_x = '0; obj_y = '0; obj_vlen = '0; obj_hflip = 1'b0;
        rom_data = '0;
        repeat (3) @(negedge clk);
        n_cmp++; if (rom_cs !== 1'b0) begin n_err++; $display("FAIL rst_rom_cs got %0b want 0", rom_cs); end
        n_cmp++; if (rom_addr !== 13'h0) begin n_err++; $display("FAIL rst_rom_addr got %h want 0", rom_addr); end
        n_cmp++; if (buf_we !== 1'b0) begin n_err++; $display("FAIL rst_buf_we got %0b want 0", buf_we); end
        n_cmp++; if (buf_addr !== 9'h0) begin n_err++; $display("FAIL rst_buf_addr got %h want 0", buf_addr); end
        n_cmp++; if (buf_data !== 8'h0) begin n_err++; $display("FAIL rst_buf_data got %h want 0", buf_data); end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (idle !== 1'b1) begin n_err++; $display("FAIL rst_idle got %0b want 1", idle); end
        n_cmp++; if (obj_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready got %0b want 1", obj_ready); end
    endtask

    // planes 0x7F: pixel 0 of each row is 0 (opaque), pixels 1..7 are 0xF (transparent)
    task automatic test_basic(input int wait_states);
        int n;
        ok_wait = wait_states;
        V = 8'h20; rom_data = 32'h7F7F7F7F;
        clear_log();
        send(8'h12, 4'hA, 9'h040, 8'h1A, 2'd0, 1'b0);
        wait_idle(n);
        n_cmp++; if (n !== 19 + 2*wait_states) begin n_err++; $display("FAIL basic_w%0d_cycles got %0d want %0d", wait_states, n, 19 + 2*wait_states); end
        n_cmp++; if (ra_q.size() !== 2) begin n_err++; $display("FAIL basic_w%0d_fetches got %0d want 2", wait_states, ra_q.size()); end
        else begin
            n_cmp++; if (ra_q[0] !== 13'h24C) begin n_err++; $display("FAIL basic_addr0 got %h want 24c", ra_q[0]); end
            n_cmp++; if (ra_q[1] !== 13'h24D) begin n_err++; $display("FAIL basic_addr1 got %h want 24d", ra_q[1]); end
        end
        n_cmp++; if (cs_cycles !== 2*(wait_states+1)) begin n_err++; $display("FAIL basic_w%0d_cs_cycles got %0d want %0d", wait_states, cs_cycles, 2*(wait_states+1)); end
        n_cmp++; if (addr_jumps !== 0) begin n_err++; $display("FAIL basic_addr_stable got %0d changes want 0", addr_jumps); end
        n_cmp++; if (wa_q.size() !== 2) begin n_err++; $display("FAIL basic_w%0d_writes got %0d want 2", wait_states, wa_q.size()); end
        else begin
            for (int i = 0; i < 2; i++) begin
                logic [8:0] ea;
                ea = 9'h040 + 9'(8*i);
                n_cmp++; if (wa_q[i] !== ea || wd_q[i] !== 8'hA0) begin
                    n_err++; $display("FAIL basic_write%0d got %h/%h want %h/a0", i, wa_q[i], wd_q[i], ea);
                end
            end
        end
        ok_wait = 0;
    endtask

    task automatic test_out_of_zone();
        V = 8'h40;
        clear_log();
        send(8'h12, 4'h1, 9'h040, 8'h20, 2'd0, 1'b0);
        n_cmp++; if (obj_ready !== 1'b0) begin n_err++; $display("FAIL ooz_ready_check got %0b want 0", obj_ready); end
        @(negedge clk);
        n_cmp++; if (obj_ready !== 1'b1 || idle !== 1'b1) begin n_err++; $display("FAIL ooz_ready_back got %0b/%0b want 1/1", obj_ready, idle); end
        repeat (5) @(negedge clk);
        n_cmp++; if (cs_cycles !== 0 || wa_q.size() !== 0) begin n_err++; $display("FAIL ooz_activity got cs=%0d we=%0d want 0/0", cs_cycles, wa_q.size()); end
    endtask

    // transparent data, so only the address stream is observed
    task automatic test_tall();
        int n;
        rom_data = 32'hFFFFFFFF; V = 8'h23;
        clear_log();
        send(8'h10, 4'h2, 9'h000, 8'h10, 2'd1, 1'b0);
        wait_idle(n);
        n_cmp++; if (ra_q.size() !== 2) begin n_err++; $display("FAIL tall_fetches got %0d want 2", ra_q.size()); end
        else begin
            n_cmp++; if (ra_q[0] !== 13'h226 || ra_q[1] !== 13'h227) begin n_err++; $display("FAIL tall_addr got %h,%h want 226,227", ra_q[0], ra_q[1]); end
        end
        n_cmp++; if (wa_q.size() !== 0) begin n_err++; $display("FAIL tall_transparent got %0d writes want 0", wa_q.size()); end
        V = 8'h30;
        clear_log();
        send(8'h10, 4'h2, 9'h000, 8'h10, 2'd1, 1'b0);
        wait_idle(n);
        n_cmp++; if (n !== 1 || cs_cycles !== 0) begin n_err++; $display("FAIL tall_reject got n=%0d cs=%0d want 1/0", n, cs_cycles); end
    endtask

    // screen flip inverts the line and the fetch order
    task automatic test_flip();
        int n;
        rom_data = 32'hFFFFFFFF; V = 8'hDF; flip = 1'b1;
        clear_log();
        send(8'h12, 4'h2, 9'h000, 8'h1A, 2'd0, 1'b0);
        wait_idle(n);
        flip = 1'b0;
        n_cmp++; if (ra_q.size() !== 2) begin n_err++; $display("FAIL flip_fetches got %0d want 2", ra_q.size()); end
        else begin
            n_cmp++; if (ra_q[0] !== 13'h24D || ra_q[1] !== 13'h24C) begin n_err++; $display("FAIL flip_addr got %h,%h want 24d,24c", ra_q[0], ra_q[1]); end
        end
    endtask

    task automatic test_hflip();
        int n;
        rom_data = 32'h00000001; V = 8'h08;
        clear_log();
        send(8'h05, 4'h3, 9'h080, 8'h00, 2'd0, 1'b1);
        wait_idle(n);
        n_cmp++; if (ra_q.size() !== 2) begin n_err++; $display("FAIL hflip_fetches got %0d want 2", ra_q.size()); end
        else begin
            n_cmp++; if (ra_q[0] !== 13'h0B1 || ra_q[1] !== 13'h0B0) begin n_err++; $display("FAIL hflip_addr got %h,%h want 0b1,0b0", ra_q[0], ra_q[1]); end
        end
        n_cmp++; if (wa_q.size() !== 16) begin n_err++; $display("FAIL hflip_writes got %0d want 16", wa_q.size()); end
        else begin
            for (int i = 0; i < 16; i++) begin
                logic [8:0] ea;
                logic [7:0] ed;
                ea = 9'h080 + 9'(i);
                ed = (i % 8 == 0) ? 8'h31 : 8'h30;
                n_cmp++; if (wa_q[i] !== ea || wd_q[i] !== ed) begin
                    n_err++; $display("FAIL hflip_write%0d got %h/%h want %h/%h", i, wa_q[i], wd_q[i], ea, ed);
                end
            end
        end
    endtask

    task automatic test_wrap();
        int n;
        rom_data = 32'h00000000; V = 8'h20;
        clear_log();
        send(8'h12, 4'h5, 9'h1FC, 8'h1A, 2'd0, 1'b0);
        wait_idle(n);
        n_cmp++; if (wa_q.size() !== 16) begin n_err++; $display("FAIL wrap_writes got %0d want 16", wa_q.size()); end
        else begin
            for (int i = 0; i < 16; i++) begin
                logic [8:0] ea;
                ea = 9'h1FC + 9'(i);
                n_cmp++; if (wa_q[i] !== ea || wd_q[i] !== 8'h50) begin
                    n_err++; $display("FAIL wrap_write%0d got %h/%h want %h/50", i, wa_q[i], wd_q[i], ea);
                end
            end
        end
    endtask

    task automatic test_start_abort();
        int k, nw;
        rom_data = 32'h00000000; V = 8'h20;
        clear_log();
        send(8'h12, 4'h6, 9'h100, 8'h1A, 2'd0, 1'b0);
        k = 0;
        while (wa_q.size() < 3 && k < 100) begin @(negedge clk); k++; end
        n_cmp++; if (k >= 100) begin n_err++; $display("FAIL abort_reach_draw got timeout want writes"); end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_cmp++; if (idle !== 1'b1 || rom_cs !== 1'b0 || buf_we !== 1'b0) begin
            n_err++; $display("FAIL abort_state got idle=%0b cs=%0b we=%0b want 1/0/0", idle, rom_cs, buf_we);
        end
        nw = wa_q.size();
        repeat (30) @(negedge clk);
        n_cmp++; if (wa_q.size() !== nw || cs_cycles !== 1) begin
            n_err++; $display("FAIL abort_quiet got writes %0d->%0d cs=%0d want no change/1", nw, wa_q.size(), cs_cycles);
        end
    endtask

    task automatic test_reset_fetch();
        int k;
        ok_wait = 1000; rom_data = 32'h00000000; V = 8'h20;
        clear_log();
        send(8'h12, 4'h6, 9'h100, 8'h1A, 2'd0, 1'b0);
        k = 0;
        while (!rom_cs && k < 20) begin @(negedge clk); k++; end
        n_cmp++; if (rom_cs !== 1'b1) begin n_err++; $display("FAIL rstf_enter_fetch got cs=%0b want 1", rom_cs); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (rom_cs !== 1'b0 || idle !== 1'b1) begin n_err++; $display("FAIL rstf_async got cs=%0b idle=%0b want 0/1", rom_cs, idle); end
        @(negedge clk);
        ok_wait = 0;
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (idle !== 1'b1 || obj_ready !== 1'b1 || rom_cs !== 1'b0) begin
            n_err++; $display("FAIL rstf_release got idle=%0b ready=%0b cs=%0b want 1/1/0", idle, obj_ready, rom_cs);
        end
    endtask

    initial begin
        test_reset();
        test_basic(0);
        test_out_of_zone();
        test_tall();
        test_flip();
        test_hflip();
        test_basic(5);
        test_wrap();
        test_start_abort();
        test_reset_fetch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
